// File: rtl/seg_scan_driver_pkg.sv
// Shared display constants for the clock display path.
// The segment patterns here are active-high, with bit0 = a through bit6 = g.
package seg_scan_driver_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg_scan_driver_bcd7_decode.sv
// Combinational BCD code to 7-segment pattern (active-high).
// Codes A-E render as a dash; BLANK_CODE renders dark so it can be used for blinking.
module bcd7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:       pattern = SEG_0;
            4'd1:       pattern = SEG_1;
            4'd2:       pattern = SEG_2;
            4'd3:       pattern = SEG_3;
            4'd4:       pattern = SEG_4;
            4'd5:       pattern = SEG_5;
            4'd6:       pattern = SEG_6;
            4'd7:       pattern = SEG_7;
            4'd8:       pattern = SEG_8;
            4'd9:       pattern = SEG_9;
            BLANK_CODE: pattern = SEG_OFF;
            default:    pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking guard.
// Digit data is snapshotted once per frame so a rollover never tears the display.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit COM_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] digit5,
    input  logic [1:0] ampm,
    input  logic       colon_on,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] com,
    output logic       frame_tk
);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("seg_scan_driver: BLANK_CYCLES must be < SCAN_DIV");
    end

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_INV    = {7{SEG_ACT_LOW}};
    localparam logic [5:0]    COM_INV    = {6{COM_ACT_LOW}};
    localparam int            SW         = NUM_DIGITS * 4;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] snap_q, snap_d;
    logic          pm_q, pm_d;
    logic          colon_q, colon_d;
    logic          first_q, first_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    com_q, com_d;
    logic          frame_tk_q, frame_tk_d;

    logic          wrap;
    logic          snap_en;
    logic          blank;
    logic          dp_lit;
    logic [3:0]    cur_code;
    logic [6:0]    cur_pat;
    logic          unused_ampm;

    assign unused_ampm = ampm[1];

    bcd7_decode u_decode (
        .code    (cur_code),
        .pattern (cur_pat)
    );

    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        snap_en = first_q | (wrap & (idx_q == 3'd5));
        blank   = (presc_q < BLANK_LIM);

        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        snap_d  = snap_q;
        pm_d    = pm_q;
        colon_d = colon_q;
        first_d = 1'b0;
        if (snap_en) begin
            snap_d  = {digit5, digit4, digit3, digit2, digit1, digit0};
            pm_d    = ampm[0];
            colon_d = colon_on;
        end

        case (idx_q)
            3'd0:    cur_code = snap_q[3:0];
            3'd1:    cur_code = snap_q[7:4];
            3'd2:    cur_code = snap_q[11:8];
            3'd3:    cur_code = snap_q[15:12];
            3'd4:    cur_code = snap_q[19:16];
            3'd5:    cur_code = snap_q[23:20];
            default: cur_code = BLANK_CODE;
        endcase

        dp_lit = (((idx_q == 3'd2) || (idx_q == 3'd4)) && colon_q) ||
                 ((idx_q == 3'd5) && pm_q);

        // Output registers reflect the current slot state, so they lag it by one cycle.
        if (blank) begin
            com_d = 6'b000000 ^ COM_INV;
            seg_d = SEG_OFF ^ SEG_INV;
            dp_d  = SEG_ACT_LOW;
        end else begin
            com_d = (6'b000001 << idx_q) ^ COM_INV;
            seg_d = cur_pat ^ SEG_INV;
            dp_d  = dp_lit ^ SEG_ACT_LOW;
        end
        frame_tk_d = snap_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= 3'd0;
            snap_q     <= {NUM_DIGITS{BLANK_CODE}};
            pm_q       <= 1'b0;
            colon_q    <= 1'b0;
            first_q    <= 1'b1;
            seg_q      <= SEG_OFF ^ SEG_INV;
            dp_q       <= SEG_ACT_LOW;
            com_q      <= COM_INV;
            frame_tk_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            pm_q       <= pm_d;
            colon_q    <= colon_d;
            first_q    <= first_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            com_q      <= com_d;
            frame_tk_q <= frame_tk_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign com      = com_q;
    assign frame_tk = frame_tk_q;

endmodule
